// File: rtl/timer_count_ctrl.sv
// timer_count_ctrl: load/idle/count sequencer for the 8-bit timer.
// Takes the TCR/TDR values held by the APB register block and runs a
// prescaler plus an up/down counter. It also keeps sticky ovf/udf status
// bits and drives a registered interrupt. Everything is on the PCLK domain.
//
// Interface note: clr_ovf_i / clr_udf_i are single-cycle pulses with no
// handshake. A pulse is sampled on the next PCLK edge. If a flag is set on
// that same edge, the set wins and the flag stays 1.
module timer_count_ctrl #(
    parameter int CNT_W = 8,
    parameter int PSC_W = 4
) (
    input  logic             PCLK,
    input  logic             PRESET,
    input  logic [7:0]       tcr_i,
    input  logic [CNT_W-1:0] tdr_i,
    input  logic             clr_ovf_i,
    input  logic             clr_udf_i,
    output logic [CNT_W-1:0] tcnt_o,
    output logic [7:0]       tsr_o,
    output logic             irq_o,
    output logic [1:0]       state_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_COUNT = 2'b10
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   tcnt_q, tcnt_d;
    logic [PSC_W-1:0]   psc_q, psc_d;
    logic [PSC_W-1:0]   div_m1;
    logic               ovf_q, udf_q;
    logic               ovf_d, udf_d;
    logic               irq_q;
    logic               tick;
    logic               ovf_set, udf_set;

    // Named control fields of TCR; bits 3:2 are reserved.
    logic       tcr_load, tcr_irq_en, tcr_down, tcr_en;
    logic [1:0] tcr_cks;
    logic       unused_tcr;

    assign tcr_load   = tcr_i[7];
    assign tcr_irq_en = tcr_i[6];
    assign tcr_down   = tcr_i[5];
    assign tcr_en     = tcr_i[4];
    assign tcr_cks    = tcr_i[1:0];
    assign unused_tcr = ^tcr_i[3:2];

    // Terminal prescaler count for the selected divide (2^(cks+1) - 1).
    always_comb begin
        div_m1 = '0;
        case (tcr_cks)
            2'b00:   div_m1 = PSC_W'(1);
            2'b01:   div_m1 = PSC_W'(3);
            2'b10:   div_m1 = PSC_W'(7);
            default: div_m1 = PSC_W'(15);
        endcase
    end

    // FSM state register.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic: load has priority over enable, from any state.
    always_comb begin
        state_d = ST_IDLE;
        if (tcr_load)    state_d = ST_LOAD;
        else if (tcr_en) state_d = ST_COUNT;
        else             state_d = ST_IDLE;
    end

    // Counter and prescaler next values.
    // Actions follow the registered state. A cks change takes effect at
    // once: the >= compare wraps a prescaler that is already past the new
    // terminal count.
    always_comb begin
        tcnt_d  = tcnt_q;
        psc_d   = psc_q;
        tick    = 1'b0;
        ovf_set = 1'b0;
        udf_set = 1'b0;
        case (state_q)
            ST_LOAD: begin
                tcnt_d = tdr_i;
                psc_d  = '0;
            end
            ST_COUNT: begin
                if (psc_q >= div_m1) begin
                    tick  = 1'b1;
                    psc_d = '0;
                    if (tcr_down) begin
                        tcnt_d  = tcnt_q - CNT_W'(1);
                        udf_set = (tcnt_q == '0);
                    end else begin
                        tcnt_d  = tcnt_q + CNT_W'(1);
                        ovf_set = (tcnt_q == {CNT_W{1'b1}});
                    end
                end else begin
                    psc_d = psc_q + PSC_W'(1);
                end
            end
            default: begin
                // Idle holds; entering COUNT restarts the prescaler.
                if (state_d == ST_COUNT) psc_d = '0;
            end
        endcase
    end

    // Sticky flags: set wins over a simultaneous clear.
    always_comb begin
        ovf_d = ovf_set | (ovf_q & ~clr_ovf_i);
        udf_d = udf_set | (udf_q & ~clr_udf_i);
    end

    // Datapath, status and interrupt registers.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            tcnt_q <= '0;
            psc_q  <= '0;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            tcnt_q <= tcnt_d;
            psc_q  <= psc_d;
            ovf_q  <= ovf_d;
            udf_q  <= udf_d;
            irq_q  <= tcr_irq_en & (ovf_d | udf_d);
        end
    end

    assign tcnt_o  = tcnt_q;
    assign tsr_o   = {6'b0, udf_q, ovf_q};
    assign irq_o   = irq_q;
    assign state_o = state_q;

endmodule
